// File: rtl/aes_mode_seq_pkg.sv
// aes_mode_seq_pkg: shared types and constants for the AES block-mode sequencer
package aes_mode_seq_pkg;
  localparam int AES_BLK_W = 128;
  localparam logic AES_MODE_ECB = 1'b0;
  localparam logic AES_MODE_CBC = 1'b1;
  localparam logic AES_DIR_ENC = 1'b0;
  localparam logic AES_DIR_DEC = 1'b1;
  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;
endpackage

// File: rtl/aes_mode_seq_if.sv
// aes_mode_seq_if: input and output block streams of the mode sequencer
interface aes_mode_seq_if;
  import aes_mode_seq_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [AES_BLK_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [AES_BLK_W-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/aes_mode_seq.sv
// aes_mode_seq: ECB/CBC block sequencer around one AES core with chain register and hang watchdog
module aes_mode_seq
  import aes_mode_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TMO_W = 8,
  parameter int unsigned BLK_CNT_W = 16
) (
  input  logic mclk,
  input  logic rst,
  input  logic cfg_en,
  input  logic cfg_mode,
  input  logic cfg_dir,
  input  logic [AES_BLK_W-1:0] cfg_iv,
  input  logic iv_ld,
  input  logic key_rdy,
  aes_mode_seq_if.slave s,
  output logic core_ld,
  output logic [AES_BLK_W-1:0] core_text_in,
  input  logic core_done,
  input  logic [AES_BLK_W-1:0] core_text_out,
  output logic [BLK_CNT_W-1:0] blk_cnt,
  output logic busy,
  output logic err_timeout
);
  state_t state, nxt;
  logic mode_q, dir_q, tmo;
  logic [AES_BLK_W-1:0] blk_q, chain;
  logic [TMO_W-1:0] wdog;
  assign s.in_ready = state == IDLE && cfg_en && key_rdy && !err_timeout && !iv_ld && !rst;
  assign tmo = state == WAIT && !core_done && wdog == TMO_W'(TIMEOUT_CYC);
  assign core_ld = state == START;
  assign busy = state != IDLE;
  // state register
  always_ff @(posedge mclk) state <= rst ? IDLE : nxt;
  // next-state: accept -> start pulse -> wait for core -> hold result until taken
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (s.in_valid && s.in_ready) ? START : IDLE;
      START:   nxt = WAIT;
      WAIT:    nxt = core_done ? OUT : tmo ? IDLE : WAIT;
      OUT:     nxt = s.out_ready ? IDLE : OUT;
      default: nxt = IDLE;
    endcase
  end
  // datapath: chaining XORs, chain register, counters and sticky timeout flag
  always_ff @(posedge mclk) begin
    if (rst) begin
      mode_q <= 1'b0;
      dir_q <= 1'b0;
      blk_q <= '0;
      chain <= '0;
      core_text_in <= '0;
      s.out_data <= '0;
      s.out_valid <= 1'b0;
      blk_cnt <= '0;
      wdog <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (!cfg_en) err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (iv_ld) begin
            chain <= cfg_iv;
            blk_cnt <= '0;
          end else if (s.in_valid && s.in_ready) begin
            mode_q <= cfg_mode;
            dir_q <= cfg_dir;
            blk_q <= s.in_data;
            core_text_in <= (cfg_mode == AES_MODE_CBC && cfg_dir == AES_DIR_ENC) ? s.in_data ^ chain : s.in_data;
          end
        end
        START: wdog <= TMO_W'(1);
        WAIT: begin
          wdog <= wdog + TMO_W'(1);
          if (core_done) begin
            s.out_data <= (mode_q == AES_MODE_CBC && dir_q == AES_DIR_DEC) ? core_text_out ^ chain : core_text_out;
            if (mode_q == AES_MODE_CBC) chain <= dir_q == AES_DIR_ENC ? core_text_out : blk_q;
            s.out_valid <= 1'b1;
          end else if (tmo) err_timeout <= 1'b1;
        end
        OUT: begin
          if (s.out_ready) begin
            s.out_valid <= 1'b0;
            blk_cnt <= blk_cnt + BLK_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
